// File: rtl/pipe_barrel_shifter.sv
// Two-stage pipelined barrel shifter with valid/ready handshake.
// Left operations are done as bit-reverse -> right shift -> bit-reverse,
// so a single logarithmic right shifter serves every mode.
module pipe_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SW-1:0]    shamt_i,
  input  logic [2:0]       mode_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_o,
  output logic             carry_o,
  output logic             zero_o
);

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  localparam logic [SW-1:0] SHAMT_ONE = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0] SHAMT_ZERO = {SW{1'b0}};

  generate
    if ((WIDTH < 32'sd4) || ((WIDTH & (WIDTH - 32'sd1)) != 32'sd0)) begin : g_bad_width
      $error("pipe_barrel_shifter: WIDTH must be a power of two and at least 4");
    end
  endgenerate

  // Mirror a word end for end.
  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = x[WIDTH-1-i];
    end
    return r;
  endfunction

  // Logarithmic right shifter: stage k moves by 2**k; vacated bits take
  // the fill bit, or the bits falling off the bottom when rotating.
  function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] x,
                                                   input logic [SW-1:0]    amt,
                                                   input logic             fill,
                                                   input logic             rot);
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    int               step;
    int               idx;
    cur = x;
    for (int k = 0; k < SW; k++) begin
      nxt  = cur;
      step = 32'sd1 << k;
      if (amt[k]) begin
        for (int i = 0; i < WIDTH; i++) begin
          idx = (i + step) % WIDTH;
          if ((i + step < WIDTH) || rot) begin
            nxt[i] = cur[idx];
          end else begin
            nxt[i] = fill;
          end
        end
      end
      cur = nxt;
    end
    return cur;
  endfunction

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_op_r;
  logic [SW-1:0]    s1_shamt_r;
  logic [2:0]       s1_mode_r;
  logic             s1_fill_r;
  logic             out_valid_r;

  logic             s1_valid_s;
  logic             s2_adv_s;
  logic             s1_adv_s;
  logic [WIDTH-1:0] s1_op_s;
  logic             s1_fill_s;
  logic             rot_s;
  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] result_s;
  logic             carry_s;
  logic [SW-1:0]    shamt_m1_s;

  // Valids are gated by rst_n so they drop the instant reset asserts.
  assign s1_valid_s = s1_valid_r & rst_n;
  assign out_valid  = out_valid_r & rst_n;
  assign s2_adv_s   = !out_valid || out_ready;
  assign s1_adv_s   = !s1_valid_s || s2_adv_s;
  assign in_ready   = s1_adv_s;
  assign shamt_m1_s = s1_shamt_r - SHAMT_ONE;

  // Stage 1 operand preparation: reverse for left ops, pick the fill bit.
  always_comb begin
    s1_op_s   = data_i;
    s1_fill_s = 1'b0;
    if ((mode_i == MODE_SLL) || (mode_i == MODE_ROL)) begin
      s1_op_s = bit_rev(data_i);
    end else begin
      s1_op_s = data_i;
    end
    if (mode_i == MODE_SRA) begin
      s1_fill_s = data_i[WIDTH-1];
    end else begin
      s1_fill_s = 1'b0;
    end
  end

  // Stage 1 register: captures a request on every input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= {WIDTH{1'b0}};
      s1_shamt_r <= SHAMT_ZERO;
      s1_mode_r  <= 3'b000;
      s1_fill_r  <= 1'b0;
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_op_r    <= s1_op_s;
        s1_shamt_r <= shamt_i;
        s1_mode_r  <= mode_i;
        s1_fill_r  <= s1_fill_s;
      end
    end
  end

  // Stage 2 datapath: right shift, undo the reversal, derive carry.
  // In the reversed/right-shift domain the last bit out is always op[n-1].
  always_comb begin
    rot_s     = (s1_mode_r == MODE_ROL) || (s1_mode_r == MODE_ROR);
    shifted_s = shift_right(s1_op_r, s1_shamt_r, s1_fill_r, rot_s);
    result_s  = s1_op_r;
    carry_s   = 1'b0;
    case (s1_mode_r)
      MODE_SLL, MODE_ROL: result_s = bit_rev(shifted_s);
      MODE_SRL, MODE_SRA, MODE_ROR: result_s = shifted_s;
      default: result_s = s1_op_r;
    endcase
    if ((s1_mode_r <= MODE_ROR) && (s1_shamt_r != SHAMT_ZERO)) begin
      carry_s = s1_op_r[shamt_m1_s];
    end else begin
      carry_s = 1'b0;
    end
  end

  // Stage 2 register: result and flags load only when S1 holds a request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      data_o      <= {WIDTH{1'b0}};
      carry_o     <= 1'b0;
      zero_o      <= 1'b0;
    end else if (s2_adv_s) begin
      out_valid_r <= s1_valid_s;
      if (s1_valid_s) begin
        data_o  <= result_s;
        carry_o <= carry_s;
        zero_o  <= (result_s == {WIDTH{1'b0}});
      end
    end
  end

endmodule
